// File: rtl/cpack_line_parser_if.sv
// Line-in / packet-out bundle between the line buffer source, the parser and
// the combinational word decoder.
`timescale 1ns/1ps
interface cpack_line_parser_if #(
  parameter int CODES     = 2,
  parameter int WORD      = 16,
  parameter int WIDTH     = 32,
  parameter int I_WORD2   = 34,
  parameter int LINE_BITS = 544,
  parameter int LEN_W     = 10
);
  logic                     i_line_valid;
  logic                     o_line_ready;
  logic [LINE_BITS-1:0]     i_line;
  logic [LEN_W-1:0]         i_len;
  logic                     o_valid;
  logic                     i_ready;
  logic [CODES-1:0]         o_codes;
  logic [CODES-1:0]         o_codes_bak;
  logic [$clog2(WORD)-1:0]  o_idx;
  logic [I_WORD2-1:0]       o_word;
  logic [WORD*WIDTH-1:0]    o_dict;
  logic [WIDTH-1:0]         i_dec_word;
  logic                     o_done;
  logic                     o_err;

  modport slave (
    input  i_line_valid, i_line, i_len, i_ready, i_dec_word,
    output o_line_ready, o_valid, o_codes, o_codes_bak, o_idx, o_word,
           o_dict, o_done, o_err
  );

  modport master (
    output i_line_valid, i_line, i_len, i_ready, i_dec_word,
    input  o_line_ready, o_valid, o_codes, o_codes_bak, o_idx, o_word,
           o_dict, o_done, o_err
  );
endinterface

// File: rtl/cpack_line_parser.sv
// Splits one compressed cache line into 16 code packets for the word decoder
// and maintains the per-line FIFO dictionary from the decoder's output.
`timescale 1ns/1ps
module cpack_line_parser #(
  parameter int CODES     = 2,
  parameter int WORD      = 16,
  parameter int WIDTH     = 32,
  parameter int I_WORD2   = 34,
  parameter int LINE_BITS = 544,
  parameter int LEN_W     = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  cpack_line_parser_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for a compressed line
  // PARSE | presenting one packet per handshake
  // DONE  | one-cycle end-of-line pulse carrying the error flag
  typedef enum logic [1:0] {S_IDLE, S_PARSE, S_DONE} state_t;

  localparam int IDX_W = $clog2(WORD);

  state_t                        state_q, state_d;
  logic [LINE_BITS-1:0]          line_q;
  logic [LEN_W-1:0]              len_q;
  logic [LEN_W-1:0]              ptr_q, ptr_d;
  logic [IDX_W-1:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic                          err_q, err_d;
  logic [WORD-1:0][WIDTH-1:0]    dict_q;

  logic [I_WORD2-1:0]            window;
  logic [CODES-1:0]              code;
  logic [CODES-1:0]              code_bak;
  logic [5:0]                    pat_len;
  logic                          reserved;
  logic                          pushes;
  logic [LEN_W:0]                sum;
  logic                          bad;
  logic                          load;
  logic                          push;
  logic                          valid;

  // Bits shifted in from beyond the buffer read as zero.
  assign window   = I_WORD2'(line_q >> ptr_q);
  assign code     = window[CODES-1:0];
  assign code_bak = window[2*CODES-1:CODES];

  always_comb begin
    pat_len  = 6'd0;
    reserved = 1'b0;
    pushes   = 1'b0;
    case (code)
      2'b00: pat_len = 6'd2;
      2'b01: begin pat_len = 6'd34; pushes = 1'b1; end
      2'b10: pat_len = 6'd6;
      default: begin
        case (code_bak)
          2'b00:   begin pat_len = 6'd24; pushes = 1'b1; end
          2'b01:   pat_len = 6'd12;
          2'b10:   begin pat_len = 6'd16; pushes = 1'b1; end
          default: reserved = 1'b1;
        endcase
      end
    endcase
  end

  assign sum = {1'b0, ptr_q} + {{(LEN_W-5){1'b0}}, pat_len};
  assign bad = reserved | (sum > {1'b0, len_q});

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    err_d    = err_q;
    load     = 1'b0;
    push     = 1'b0;
    valid    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_line_valid) begin
          load     = 1'b1;
          ptr_d    = '0;
          cnt_d    = '0;
          wr_ptr_d = '0;
          err_d    = 1'b0;
          state_d  = S_PARSE;
        end
      end
      S_PARSE: begin
        if (bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          valid = 1'b1;
          if (bus.i_ready) begin
            ptr_d = sum[LEN_W-1:0];
            cnt_d = cnt_q + 1'b1;
            push  = pushes;
            if (pushes) wr_ptr_d = wr_ptr_q + 1'b1;
            if (cnt_q == IDX_W'(WORD-1)) begin
              err_d   = (sum != {1'b0, len_q});
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      line_q   <= '0;
      len_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      err_q    <= 1'b0;
      dict_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      err_q    <= err_d;
      if (load) begin
        line_q <= bus.i_line;
        len_q  <= bus.i_len;
        dict_q <= '0;
      end else if (push) begin
        dict_q[wr_ptr_q] <= bus.i_dec_word;
      end
    end
  end

  assign bus.o_line_ready = (state_q == S_IDLE);
  assign bus.o_valid      = valid;
  assign bus.o_codes      = code;
  assign bus.o_codes_bak  = code_bak;
  // mmmm carries its index right after the code; the other forms after the backup code.
  assign bus.o_idx        = (code == 2'b10) ? window[5:2] : window[7:4];
  assign bus.o_word       = window;
  assign bus.o_dict       = dict_q;
  assign bus.o_done       = (state_q == S_DONE);
  assign bus.o_err        = (state_q == S_DONE) & err_q;
endmodule

// File: tb/tb_cpack_line_parser.sv
// Directed scoreboard bench for cpack_line_parser with a behavioural word
// decoder closing the dictionary loop.
`timescale 1ns/1ps
module tb_cpack_line_parser;
  localparam int LINE_BITS = 544;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpack_line_parser_if bus ();
  cpack_line_parser dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

  typedef struct { int ptr; logic [31:0] dec; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pkt_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic done_err = 1'b0;
  logic stall_mode = 1'b0;
  logic stalled_prev = 1'b0;
  logic [33:0] held_word;
  logic [LINE_BITS-1:0] line_r = '0;
  logic [LINE_BITS-1:0] bld_line;
  int bld_ptr;
  logic [31:0] ref_dict [16];
  int ref_wp;
  logic [31:0] dent, dec_word;
  logic [33:0] mw;
  exp_t e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural word decoder fed from the parser's packet and dictionary.
  always_comb begin
    dent     = bus.o_dict[32*bus.o_idx +: 32];
    dec_word = '0;
    case (bus.o_codes)
      2'b00: dec_word = '0;
      2'b01: dec_word = bus.o_word[33:2];
      2'b10: dec_word = dent;
      default: begin
        case (bus.o_codes_bak)
          2'b00:   dec_word = {dent[31:16], bus.o_word[23:8]};
          2'b01:   dec_word = {24'h0, bus.o_word[11:4]};
          2'b10:   dec_word = {dent[31:8], bus.o_word[15:8]};
          default: dec_word = '0;
        endcase
      end
    endcase
  end
  assign bus.i_dec_word = dec_word;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.i_ready = stall_mode ? ~bus.i_ready : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        chk("stall_valid", bus.o_valid, 1);
        chk("stall_word", bus.o_word, held_word);
      end
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pkt", pkt_cnt, -1);
        end else begin
          e  = exp_q.pop_front();
          mw = 34'(line_r >> e.ptr);
          chk("pkt_word", bus.o_word, mw);
          chk("pkt_code", bus.o_codes, mw[1:0]);
          chk("pkt_bak", bus.o_codes_bak, mw[3:2]);
          chk("pkt_idx", bus.o_idx, (mw[1:0] == 2'b10) ? mw[5:2] : mw[7:4]);
          chk("pkt_dec", dec_word, e.dec);
        end
        pkt_cnt++;
      end
      stalled_prev = bus.o_valid & ~bus.i_ready;
      held_word    = bus.o_word;
      if (bus.o_done) begin
        done_cnt++;
        done_err = bus.o_err;
        done_cyc = cyc;
      end
    end
  end

  task automatic begin_line();
    bld_line = '0;
    bld_ptr  = 0;
    ref_wp   = 0;
    for (int k = 0; k < 16; k++) ref_dict[k] = '0;
    exp_q.delete();
  endtask

  task automatic put(input logic [33:0] bits, input int n, input logic [31:0] dec, input logic push);
    exp_t x;
    x.ptr = bld_ptr;
    x.dec = dec;
    exp_q.push_back(x);
    for (int b = 0; b < n; b++) bld_line[bld_ptr+b] = bits[b];
    bld_ptr += n;
    if (push) begin
      ref_dict[ref_wp] = dec;
      ref_wp = (ref_wp + 1) % 16;
    end
  endtask

  task automatic p_z();                                   put(34'h0, 2, 32'h0, 1'b0); endtask
  task automatic p_x(input logic [31:0] v);               put({v, 2'b01}, 34, v, 1'b1); endtask
  task automatic p_m(input logic [3:0] i);                put({28'h0, i, 2'b10}, 6, ref_dict[i], 1'b0); endtask
  task automatic p_mx(input logic [3:0] i, input logic [15:0] d);
    put({10'h0, d, i, 4'b0011}, 24, {ref_dict[i][31:16], d}, 1'b1);
  endtask
  task automatic p_zx(input logic [7:0] b);               put({22'h0, b, 4'b0111}, 12, {24'h0, b}, 1'b0); endtask
  task automatic p_mmx(input logic [3:0] i, input logic [7:0] b);
    put({18'h0, b, i, 4'b1011}, 16, {ref_dict[i][31:8], b}, 1'b1);
  endtask
  task automatic p_res();
    for (int b = 0; b < 4; b++) bld_line[bld_ptr+b] = 1'b1;
    bld_ptr += 4;
  endtask

  task automatic run_line(input int len, input logic exp_err, input int exp_pkts,
                          input logic stall, input logic chk_lat);
    int pb, db, acc;
    @(posedge clk); #1;
    chk("line_ready_idle", bus.o_line_ready, 1);
    line_r = bld_line;
    bus.i_line = bld_line;
    bus.i_len = 10'(len);
    bus.i_line_valid = 1'b1;
    stall_mode = stall;
    pb = pkt_cnt;
    db = done_cnt;
    @(posedge clk); #1;
    bus.i_line_valid = 1'b0;
    acc = cyc;
    chk("line_ready_busy", bus.o_line_ready, 0);
    for (int i = 0; i < 80 && done_cnt == db; i++) @(negedge clk);
    chk("done_seen", done_cnt - db, 1);
    chk("done_err", done_err, exp_err);
    chk("pkt_count", pkt_cnt - pb, exp_pkts);
    chk("queue_empty", exp_q.size(), 0);
    if (chk_lat) chk("done_latency", done_cyc - acc, 16);
    for (int k = 0; k < 16; k++)
      chk($sformatf("dict%0d", k), bus.o_dict[k*32 +: 32], ref_dict[k]);
    stall_mode = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pb, db;
    bus.i_line_valid = 1'b0;
    bus.i_line = '0;
    bus.i_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line_ready", bus.o_line_ready, 1);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_dict", |bus.o_dict, 0);
    rst = 1'b0;

    // 16 zero words at full rate
    begin_line();
    for (int i = 0; i < 16; i++) p_z();
    run_line(32, 1'b0, 16, 1'b0, 1'b1);

    // literal then full match of it
    begin_line();
    p_x(32'hDEADBEEF); p_m(4'd0);
    for (int i = 0; i < 14; i++) p_z();
    run_line(68, 1'b0, 16, 1'b0, 1'b1);

    // partial matches and zero-extended byte
    begin_line();
    p_x(32'hAABBCCDD); p_mx(4'd0, 16'h1234); p_zx(8'h5A); p_mmx(4'd1, 8'h77);
    for (int i = 0; i < 12; i++) p_z();
    run_line(110, 1'b0, 16, 1'b0, 1'b1);

    // dictionary fills completely and write pointer wraps
    begin_line();
    for (int i = 0; i < 16; i++) p_x(32'h1000_0000 + i * 32'h0101_0101);
    run_line(544, 1'b0, 16, 1'b0, 1'b1);

    // reserved code at word 3
    begin_line();
    p_x(32'h11111111); p_z(); p_res();
    run_line(100, 1'b1, 2, 1'b0, 1'b0);

    // length overrun on the last word
    begin_line();
    for (int i = 0; i < 15; i++) p_z();
    run_line(30, 1'b1, 15, 1'b0, 1'b0);

    // backpressure with stable outputs
    begin_line();
    p_x(32'hCAFEF00D); p_m(4'd0); p_mx(4'd0, 16'hBEEF); p_mmx(4'd1, 8'h42); p_zx(8'hA5);
    for (int i = 0; i < 11; i++) p_x(32'h0F0F0000 + i);
    run_line(34 + 6 + 24 + 16 + 12 + 11 * 34, 1'b0, 16, 1'b1, 1'b0);

    // asynchronous reset mid-line
    begin_line();
    for (int i = 0; i < 16; i++) p_x(32'h5500_0000 + i);
    @(posedge clk); #1;
    line_r = bld_line;
    bus.i_line = bld_line;
    bus.i_len = 10'd544;
    bus.i_line_valid = 1'b1;
    pb = pkt_cnt;
    db = done_cnt;
    @(posedge clk); #1;
    bus.i_line_valid = 1'b0;
    for (int i = 0; i < 40 && (pkt_cnt - pb) < 8; i++) @(negedge clk);
    chk("rst_mid_pkts", pkt_cnt - pb, 8);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", bus.o_valid, 0);
    chk("rst_mid_done", bus.o_done, 0);
    chk("rst_mid_ready", bus.o_line_ready, 1);
    chk("rst_mid_dict", |bus.o_dict, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - db, 0);
    chk("rst_mid_ready_after", bus.o_line_ready, 1);

    // clean line after the abort
    begin_line();
    p_x(32'h01234567); p_mmx(4'd0, 8'h89);
    for (int i = 0; i < 14; i++) p_z();
    run_line(34 + 16 + 28, 1'b0, 16, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
